// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcodes, ALU op codes, immediate types and immediate generator
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Sign-extended immediate for the given encoding format; IMM_NONE yields 0.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_type_e t);
    logic [31:0] v;
    v = '0;
    case (t)
      IMM_I:   v = {{20{i[31]}}, i[31:20]};
      IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   v = {i[31:12], 12'b0};
      IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file with x0 hardwired to zero
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [AW-1:0]   i_rd_addr1,
  input  logic [AW-1:0]   i_rd_addr2,
  output logic [XLEN-1:0] o_rd_data1,
  output logic [XLEN-1:0] o_rd_data2
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Clear on reset (reset beats any write); otherwise commit writes except to x0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Reads are asynchronous with no write bypass, so they show the pre-edge contents.
  assign o_rd_data1 = (i_rd_addr1 == '0) ? '0 : r_regs[i_rd_addr1];
  assign o_rd_data2 = (i_rd_addr2 == '0) ? '0 : r_regs[i_rd_addr2];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode: register file, immediates, control bundle, instret
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instruction,
  input  logic             i_wb_en,
  input  logic [4:0]       i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  output logic [XLEN-1:0]  o_imm,
  output logic [4:0]       o_rd,
  output logic [3:0]       o_alu_op,
  output logic             o_alu_src,
  output logic             o_reg_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_mem_to_reg,
  output logic             o_branch,
  output logic             o_jump,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instret
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  alu_op_e         w_alu_op;
  imm_type_e       w_imm_type;
  logic            w_alu_src;
  logic            w_reg_write;
  logic            w_mem_read;
  logic            w_mem_write;
  logic            w_mem_to_reg;
  logic            w_branch;
  logic            w_jump;
  logic            w_illegal;
  logic [CNT_W-1:0] r_instret;

  assign w_opcode = i_instruction[6:0];
  assign w_funct3 = i_instruction[14:12];
  assign w_funct7 = i_instruction[31:25];

  reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (5)
  ) u_reg_file (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_en    (i_wb_en),
    .i_wr_addr  (i_wb_rd),
    .i_wr_data  (i_wb_data),
    .i_rd_addr1 (i_instruction[19:15]),
    .i_rd_addr2 (i_instruction[24:20]),
    .o_rd_data1 (o_rs1_data),
    .o_rd_data2 (o_rs2_data)
  );

  // Opcode/funct decode into raw control strobes, immediate format and ALU op.
  always_comb begin
    w_alu_op     = ALU_ADD;
    w_imm_type   = IMM_NONE;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_imm_type  = IMM_U;
        w_alu_op    = ALU_PASSB;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_imm_type  = IMM_U;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_JAL: begin
        w_imm_type  = IMM_J;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      OP_JALR: begin
        w_imm_type  = IMM_I;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_illegal   = (w_funct3 != 3'b000);
      end
      OP_BRANCH: begin
        w_imm_type = IMM_B;
        w_branch   = 1'b1;
        case (w_funct3)
          3'b000, 3'b001: w_alu_op = ALU_SUB;
          3'b100, 3'b101: w_alu_op = ALU_SLT;
          3'b110, 3'b111: w_alu_op = ALU_SLTU;
          default:        w_illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_imm_type   = IMM_I;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_illegal    = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OP_STORE: begin
        w_imm_type  = IMM_S;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_illegal   = (w_funct3[2] == 1'b1) || (w_funct3 == 3'b011);
      end
      OP_IMM: begin
        w_imm_type  = IMM_I;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        case (w_funct3)
          3'b000: w_alu_op = ALU_ADD;
          3'b010: w_alu_op = ALU_SLT;
          3'b011: w_alu_op = ALU_SLTU;
          3'b100: w_alu_op = ALU_XOR;
          3'b110: w_alu_op = ALU_OR;
          3'b111: w_alu_op = ALU_AND;
          3'b001: begin
            w_alu_op  = ALU_SLL;
            w_illegal = (w_funct7 != F7_BASE);
          end
          default: begin
            w_alu_op  = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
        endcase
      end
      OP_OP: begin
        w_reg_write = 1'b1;
        if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            3'b000:  w_alu_op = ALU_ADD;
            3'b001:  w_alu_op = ALU_SLL;
            3'b010:  w_alu_op = ALU_SLT;
            3'b011:  w_alu_op = ALU_SLTU;
            3'b100:  w_alu_op = ALU_XOR;
            3'b101:  w_alu_op = ALU_SRL;
            3'b110:  w_alu_op = ALU_OR;
            default: w_alu_op = ALU_AND;
          endcase
        end else if ((w_funct7 == F7_ALT) && (w_funct3 == 3'b000)) begin
          w_alu_op = ALU_SUB;
        end else if ((w_funct7 == F7_ALT) && (w_funct3 == 3'b101)) begin
          w_alu_op = ALU_SRA;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_FENCE, OP_SYSTEM: begin
        w_imm_type = IMM_I;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // An illegal instruction must not change architectural state, so its strobes are masked.
  always_comb begin
    o_imm        = imm_gen(i_instruction, w_illegal ? IMM_NONE : w_imm_type);
    o_rd         = i_instruction[11:7];
    o_alu_op     = w_alu_op;
    o_alu_src    = w_alu_src & ~w_illegal;
    o_reg_write  = w_reg_write & ~w_illegal;
    o_mem_read   = w_mem_read & ~w_illegal;
    o_mem_write  = w_mem_write & ~w_illegal;
    o_mem_to_reg = w_mem_to_reg & ~w_illegal;
    o_branch     = w_branch & ~w_illegal;
    o_jump       = w_jump & ~w_illegal;
    o_illegal    = w_illegal;
  end

  // Retired-instruction counter: counts legal instructions, wraps silently.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_instret <= '0;
    end else if (!w_illegal) begin
      r_instret <= r_instret + 1'b1;
    end
  end

  assign o_instret = r_instret;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
  import rv32i_pkg::*;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump, illegal;
  logic [63:0] instret;

  logic        s_reset;
  logic [31:0] s_rs1, s_rs2, s_imm;
  logic [4:0]  s_rd;
  logic [3:0]  s_alu_op;
  logic        s_alu_src, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg;
  logic        s_branch, s_jump, s_illegal;
  logic [3:0]  s_instret;

  int          n_checks;
  int          n_pass;
  logic [63:0] exp_cnt;
  logic        cur_illegal;

  decode_stage u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_instruction (instr),
    .i_wb_en       (wb_en),
    .i_wb_rd       (wb_rd),
    .i_wb_data     (wb_data),
    .o_rs1_data    (rs1_data),
    .o_rs2_data    (rs2_data),
    .o_imm         (imm),
    .o_rd          (rd),
    .o_alu_op      (alu_op),
    .o_alu_src     (alu_src),
    .o_reg_write   (reg_write),
    .o_mem_read    (mem_read),
    .o_mem_write   (mem_write),
    .o_mem_to_reg  (mem_to_reg),
    .o_branch      (branch),
    .o_jump        (jump),
    .o_illegal     (illegal),
    .o_instret     (instret)
  );

  decode_stage #(.CNT_W(4)) u_small (
    .i_clk         (clk),
    .i_reset       (s_reset),
    .i_instruction (NOP),
    .i_wb_en       (1'b0),
    .i_wb_rd       (5'd0),
    .i_wb_data     (32'd0),
    .o_rs1_data    (s_rs1),
    .o_rs2_data    (s_rs2),
    .o_imm         (s_imm),
    .o_rd          (s_rd),
    .o_alu_op      (s_alu_op),
    .o_alu_src     (s_alu_src),
    .o_reg_write   (s_reg_write),
    .o_mem_read    (s_mem_read),
    .o_mem_write   (s_mem_write),
    .o_mem_to_reg  (s_mem_to_reg),
    .o_branch      (s_branch),
    .o_jump        (s_jump),
    .o_illegal     (s_illegal),
    .o_instret     (s_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One rising edge; the bench's own instret model advances alongside it.
  task automatic step();
    @(posedge clk);
    if (reset) exp_cnt = '0;
    else if (!cur_illegal) exp_cnt = exp_cnt + 64'd1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    exp_cnt = '0;
    cur_illegal = 1'b0;
    reset = 1'b1;
    s_reset = 1'b1;
    instr = NOP;
    wb_en = 1'b0;
    wb_rd = 5'd0;
    wb_data = 32'd0;

    repeat (2) step();
    reset = 1'b0;
    instr = 32'h00528033;
    #1;
    check("rst_instret", instret, 64'd0);
    check("rst_rs1_x5", {32'd0, rs1_data}, 64'd0);
    check("rst_rs2_x5", {32'd0, rs2_data}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    instr = NOP;
    #1;
    check("nop_illegal", {63'd0, illegal}, 64'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("instret_%0d", i), instret, 64'(i));
    end

    instr = 32'h00028013;
    wb_en = 1'b1;
    wb_rd = 5'd5;
    wb_data = 32'hDEADBEEF;
    #1;
    check("x5_pre_edge", {32'd0, rs1_data}, 64'd0);
    step();
    check("x5_post_edge", {32'd0, rs1_data}, 64'hDEADBEEF);
    instr = NOP;
    wb_rd = 5'd0;
    wb_data = 32'h1234;
    step();
    check("x0_after_wr", {32'd0, rs1_data}, 64'd0);
    wb_en = 1'b0;
    instr = 32'h00528033;
    #1;
    check("x5_rs2_keep", {32'd0, rs2_data}, 64'hDEADBEEF);

    instr = 32'hFE000EE3;
    #1;
    check("beq_imm", {32'd0, imm}, 64'hFFFFFFFC);
    check("beq_branch", {63'd0, branch}, 64'd1);
    check("beq_reg_write", {63'd0, reg_write}, 64'd0);
    check("beq_alu_op", {60'd0, alu_op}, {60'd0, ALU_SUB});
    instr = 32'h800000EF;
    #1;
    check("jal_imm", {32'd0, imm}, 64'hFFF00000);
    check("jal_jump", {63'd0, jump}, 64'd1);
    check("jal_reg_write", {63'd0, reg_write}, 64'd1);
    check("jal_rd", {59'd0, rd}, 64'd1);
    instr = 32'hFFF00093;
    #1;
    check("addi_imm", {32'd0, imm}, 64'hFFFFFFFF);
    check("addi_alu_src", {63'd0, alu_src}, 64'd1);
    check("addi_reg_write", {63'd0, reg_write}, 64'd1);
    instr = 32'h12345037;
    #1;
    check("lui_imm", {32'd0, imm}, 64'h12345000);
    check("lui_alu_op", {60'd0, alu_op}, {60'd0, ALU_PASSB});
    step();
    check("instret_model", instret, exp_cnt);

    instr = 32'h00018013;
    wb_en = 1'b1;
    wb_rd = 5'd3;
    wb_data = 32'hA5A5;
    step();
    check("x3_written", {32'd0, rs1_data}, 64'hA5A5);
    wb_en = 1'b0;

    instr = 32'hFFFFFFFF;
    cur_illegal = 1'b1;
    #1;
    check("ill_flag", {63'd0, illegal}, 64'd1);
    check("ill_strobes", {59'd0, reg_write, mem_read, mem_write, branch, jump}, 64'd0);
    check("ill_imm", {32'd0, imm}, 64'd0);
    step();
    check("ill_instret_hold", instret, exp_cnt);
    step();
    check("ill_instret_hold2", instret, exp_cnt);

    reset = 1'b1;
    wb_en = 1'b1;
    wb_rd = 5'd3;
    wb_data = 32'h5555;
    step();
    reset = 1'b0;
    wb_en = 1'b0;
    instr = 32'h00018013;
    cur_illegal = 1'b0;
    #1;
    check("x3_reset_wins", {32'd0, rs1_data}, 64'd0);
    check("reset_instret", instret, 64'd0);

    step();
    s_reset = 1'b0;
    #1;
    check("small_start", {60'd0, s_instret}, 64'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("small_wrap_%0d", i), {60'd0, s_instret}, 64'(i % 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
